// File: rtl/ntt_arb_pkg.sv
// Shared constants and the round-robin search helper for the NTT memory arbiter.
package ntt_arb_pkg;

    localparam int DATA_W              = 64;
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int MAX_CORES           = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_sel_t;

    // First set bit of req_vec at or after ptr, wrapping modulo n_cores.
    function automatic rr_sel_t rr_select(input logic [7:0] req_vec,
                                          input logic [2:0] ptr,
                                          input int         n_cores);
        rr_sel_t res;
        int      cand;
        res.found = 1'b0;
        res.idx   = 3'd0;
        for (int off = 0; off < MAX_CORES; off++) begin
            cand = (int'(ptr) + off) % n_cores;
            if ((off < n_cores) && !res.found && req_vec[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ntt_tag_fifo.sv
// Read-tag FIFO: remembers which core issued each outstanding read, in issue order.
module ntt_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_data,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty
);
    import ntt_arb_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against occupancy so the FIFO can never over- or underflow.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
    end

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = mem_r[rd_ptr_r];

    // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ntt_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among the NTT cores, with
// in-order read response routing through a tag FIFO.
module ntt_mem_arbiter
    import ntt_arb_pkg::*;
#(
    parameter int N_CORES         = 4,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int TAG_W           = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES-1:0]          s_req,
    input  logic [N_CORES-1:0]          s_we,
    input  logic [N_CORES*DATA_W-1:0]   s_addr,
    input  logic [N_CORES*DATA_W-1:0]   s_wdata,
    output logic [N_CORES-1:0]          s_gnt,
    output logic [N_CORES-1:0]          s_valid,
    output logic [DATA_W-1:0]           s_rdata,
    output logic                        m_req,
    output logic                        m_we,
    output logic [DATA_W-1:0]           m_addr,
    output logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_gnt,
    input  logic                        m_valid,
    input  logic [DATA_W-1:0]           m_rdata,
    output logic [31:0]                 grant_count,
    output logic [31:0]                 stall_count,
    output logic                        err_spurious
);

    logic [N_CORES-1:0] elig_s;
    logic [7:0]         elig8_s;
    rr_sel_t            pick_s;
    logic [TAG_W-1:0]   sel_s;
    logic [TAG_W-1:0]   rr_ptr_r;
    logic [TAG_W-1:0]   head_s;
    logic               full_s;
    logic               empty_s;
    logic               grant_s;
    logic               push_s;
    logic               pop_s;
    logic               stall_s;
    logic [31:0]        grant_count_r;
    logic [31:0]        stall_count_r;
    logic               err_spurious_r;

    // Eligibility: writes always, reads only while a tag slot is free.
    always_comb begin
        elig_s  = {N_CORES{1'b0}};
        elig8_s = 8'd0;
        for (int i = 0; i < N_CORES; i++) begin
            elig_s[i] = s_req[i] & (s_we[i] | ~full_s);
        end
        elig8_s[N_CORES-1:0] = elig_s;
        pick_s = rr_select(elig8_s, 3'(rr_ptr_r), N_CORES);
        sel_s  = TAG_W'(pick_s.idx);
    end

    // Master-side mux and same-cycle grant; everything is forced low in reset.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = {DATA_W{1'b0}};
        m_wdata = {DATA_W{1'b0}};
        s_gnt   = {N_CORES{1'b0}};
        if (!rst && pick_s.found) begin
            m_req   = 1'b1;
            m_we    = s_we[sel_s];
            m_addr  = s_addr[sel_s*DATA_W +: DATA_W];
            m_wdata = s_wdata[sel_s*DATA_W +: DATA_W];
        end else begin
            m_req = 1'b0;
        end
        grant_s = m_req & m_gnt;
        if (grant_s) begin
            s_gnt[sel_s] = 1'b1;
        end else begin
            s_gnt = {N_CORES{1'b0}};
        end
        push_s  = grant_s & ~m_we;
        stall_s = (|s_req) & ~(|s_gnt);
    end

    // Response routing: the head tag picks the core that sees s_valid.
    always_comb begin
        s_valid = {N_CORES{1'b0}};
        pop_s   = m_valid & ~empty_s & ~rst;
        if (pop_s) begin
            s_valid[head_s] = 1'b1;
        end else begin
            s_valid = {N_CORES{1'b0}};
        end
        if (rst) begin
            s_rdata = {DATA_W{1'b0}};
        end else begin
            s_rdata = m_rdata;
        end
    end

    ntt_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (sel_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Round-robin pointer, transaction/stall counters and sticky spurious-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r       <= {TAG_W{1'b0}};
            grant_count_r  <= 32'd0;
            stall_count_r  <= 32'd0;
            err_spurious_r <= 1'b0;
        end else begin
            if (grant_s) begin
                if (sel_s == TAG_W'(N_CORES - 1)) begin
                    rr_ptr_r <= {TAG_W{1'b0}};
                end else begin
                    rr_ptr_r <= sel_s + TAG_W'(1);
                end
                grant_count_r <= grant_count_r + 32'd1;
            end
            if (stall_s) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
            if (m_valid && empty_s) begin
                err_spurious_r <= 1'b1;
            end
        end
    end

    assign grant_count  = grant_count_r;
    assign stall_count  = stall_count_r;
    assign err_spurious = err_spurious_r;

endmodule
